// File: rtl/rvfi_trace_pkg.sv
// RVFI trace transmitter shared types.
// Buffered record layout and packet byte mapping.
package rvfi_trace_pkg;

    localparam int PKT_BYTES = 16;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_e;

    typedef struct packed {
        logic [2:0]  seq;
        logic        ovf;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [4:0]  rs1_addr;
        logic [31:0] rs1_rdata;
        logic [4:0]  rs2_addr;
        logic [31:0] rs2_rdata;
    } rvfi_rec_t;

    function automatic logic [7:0] pkt_byte(
        input rvfi_rec_t  r,
        input logic [3:0] idx,
        input logic [7:0] sync
    );
        logic [7:0] b;
        unique case (idx)
            4'd0:    b = sync;
            4'd1:    b = {r.seq, r.rd_addr};
            4'd2:    b = r.rd_wdata[7:0];
            4'd3:    b = r.rd_wdata[15:8];
            4'd4:    b = r.rd_wdata[23:16];
            4'd5:    b = r.rd_wdata[31:24];
            4'd6:    b = {r.ovf, 2'b00, r.rs1_addr};
            4'd7:    b = r.rs1_rdata[7:0];
            4'd8:    b = r.rs1_rdata[15:8];
            4'd9:    b = r.rs1_rdata[23:16];
            4'd10:   b = r.rs1_rdata[31:24];
            4'd11:   b = {3'b000, r.rs2_addr};
            4'd12:   b = r.rs2_rdata[7:0];
            4'd13:   b = r.rs2_rdata[15:8];
            4'd14:   b = r.rs2_rdata[23:16];
            default: b = r.rs2_rdata[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rvfi_rec_fifo.sv
// Synchronous record FIFO for the RVFI trace transmitter.
// A push while full is taken only when the head pops in the same cycle.
module rvfi_rec_fifo
    import rvfi_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  rvfi_rec_t               wdata_i,
    output rvfi_rec_t               rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    rvfi_rec_t       mem_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [AW:0]     level_q;
    logic            wr;
    logic            rd;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign rd      = pop_i && !empty_o;
    assign wr      = push_i && (!full_o || rd);
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (wr) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd) begin
                rptr_q <= rptr_q + AW'(1);
            end
            unique case ({wr, rd})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/rvfi_trace_tx.sv
// RVFI retirement trace transmitter: buffers retired-instruction records
// and serialises each as a 16-byte packet on an 8-bit valid/ready stream.
module rvfi_trace_tx
    import rvfi_trace_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    rvfi_valid,
    input  logic [4:0]              rvfi_rd_addr,
    input  logic [31:0]             rvfi_rd_wdata,
    input  logic [4:0]              rvfi_rs1_addr,
    input  logic [31:0]             rvfi_rs1_rdata,
    input  logic [4:0]              rvfi_rs2_addr,
    input  logic [31:0]             rvfi_rs2_rdata,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_last,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [15:0]             drop_count
);

    localparam int         LW       = $clog2(DEPTH) + 1;
    localparam logic [3:0] LAST_IDX = 4'(PKT_BYTES - 1);

    tx_state_e   state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  seq_q;
    logic        ovf_q;
    logic [15:0] drop_q;

    logic        capture;
    logic        push;
    logic        pop;
    logic        drop;
    logic        full;
    logic        empty;
    rvfi_rec_t   wrec;
    rvfi_rec_t   head;

    assign capture = en && rvfi_valid;
    assign pop     = (state_q == SEND) && tx_ready && (idx_q == LAST_IDX);
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    assign wrec = '{
        seq:       seq_q,
        ovf:       ovf_q,
        rd_addr:   rvfi_rd_addr,
        rd_wdata:  rvfi_rd_wdata,
        rs1_addr:  rvfi_rs1_addr,
        rs1_rdata: rvfi_rs1_rdata,
        rs2_addr:  rvfi_rs2_addr,
        rs2_rdata: rvfi_rs2_rdata
    };

    rvfi_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wrec),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (push) begin
                seq_q <= seq_q + 3'd1;
                ovf_q <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_q <= drop_q + 16'd1;
                end
            end
        end
    end

    // Leaving SEND needs the post-pop occupancy, including a same-cycle push.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = pkt_byte(head, idx_q, SYNC_BYTE);
                tx_last  = (idx_q == LAST_IDX);
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (fifo_level == LW'(1) && !push) begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign drop_count = drop_q;

endmodule

// File: tb/tb_rvfi_trace_tx.sv
// Self-checking bench for rvfi_trace_tx.
// Scoreboard model of capture, drop and packet serialisation.
module tb_rvfi_trace_tx;

    localparam int         DEPTH = 4;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rvfi_valid;
    logic        tx_ready;
    logic [4:0]  rvfi_rd_addr;
    logic [4:0]  rvfi_rs1_addr;
    logic [4:0]  rvfi_rs2_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_rs1_rdata;
    logic [31:0] rvfi_rs2_rdata;
    logic        tx_valid;
    logic        tx_last;
    logic [7:0]  tx_data;
    logic [2:0]  fifo_level;
    logic [15:0] drop_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    bit         obs_last_q[$];
    int         m_count;
    int         m_seq;
    int         m_drop;
    int         hs_cnt;
    bit         m_ovf;

    logic       s_valid;
    logic       s_last;
    logic [7:0] s_data;

    always #5 clk = ~clk;

    rvfi_trace_tx #(
        .DEPTH     (DEPTH),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .rvfi_valid     (rvfi_valid),
        .rvfi_rd_addr   (rvfi_rd_addr),
        .rvfi_rd_wdata  (rvfi_rd_wdata),
        .rvfi_rs1_addr  (rvfi_rs1_addr),
        .rvfi_rs1_rdata (rvfi_rs1_rdata),
        .rvfi_rs2_addr  (rvfi_rs2_addr),
        .rvfi_rs2_rdata (rvfi_rs2_rdata),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx_last        (tx_last),
        .fifo_level     (fifo_level),
        .drop_count     (drop_count)
    );

    task automatic set_rand();
        rvfi_rd_addr   = 5'($urandom);
        rvfi_rs1_addr  = 5'($urandom);
        rvfi_rs2_addr  = 5'($urandom);
        rvfi_rd_wdata  = $urandom;
        rvfi_rs1_rdata = $urandom;
        rvfi_rs2_rdata = $urandom;
    endtask

    // One clock: drive inputs, observe at negedge, advance the model.
    task automatic tick(input bit v, input bit r, input bit e);
        bit pop;
        rvfi_valid = v;
        tx_ready   = r;
        en         = e;
        @(negedge clk);
        s_valid = tx_valid;
        s_data  = tx_data;
        s_last  = tx_last;
        pop     = 1'b0;
        if (tx_valid && tx_ready) begin
            obs_q.push_back(tx_data);
            obs_last_q.push_back(tx_last);
            pop = (hs_cnt % 16 == 15);
            hs_cnt++;
        end
        if (e && v) begin
            if (m_count < DEPTH || pop) begin
                exp_q.push_back(SYNC);
                exp_q.push_back({3'(m_seq), rvfi_rd_addr});
                for (int i = 0; i < 4; i++) exp_q.push_back(8'(rvfi_rd_wdata >> (8 * i)));
                exp_q.push_back({m_ovf, 2'b00, rvfi_rs1_addr});
                for (int i = 0; i < 4; i++) exp_q.push_back(8'(rvfi_rs1_rdata >> (8 * i)));
                exp_q.push_back({3'b000, rvfi_rs2_addr});
                for (int i = 0; i < 4; i++) exp_q.push_back(8'(rvfi_rs2_rdata >> (8 * i)));
                m_seq = (m_seq + 1) % 8;
                m_ovf = 1'b0;
                m_count++;
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
        end
        if (pop) m_count--;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        en         = 1'b0;
        rvfi_valid = 1'b0;
        tx_ready   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        obs_q.delete();
        obs_last_q.delete();
        m_count = 0;
        m_seq   = 0;
        m_drop  = 0;
        hs_cnt  = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while ((m_count > 0 || tx_valid) && n < 2000) begin
            tick(1'b0, 1'b1, 1'b1);
            n++;
        end
        ok = (n < 2000);
    endtask

    // Index of first stream disagreement, -2 on length mismatch, -1 if equal.
    function automatic int first_diff();
        if (obs_q.size() != exp_q.size()) return -2;
        foreach (obs_q[i]) begin
            if (obs_q[i] !== exp_q[i] || obs_last_q[i] !== (i % 16 == 15)) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || tx_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx: valid=%b data=%h last=%b want 0/00/0", tx_valid, tx_data, tx_last);
        end
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_level: got %0d want 0", fifo_level);
        end
        checks++;
        if (drop_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_drop: got %0d want 0", drop_count);
        end
    endtask

    task automatic test_single();
        logic [7:0] gold [16];
        bit ok;
        int d;
        gold = '{8'hA5, 8'h07, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h07, 8'h44,
                 8'h33, 8'h22, 8'h11, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        rvfi_rd_addr   = 5'd7;
        rvfi_rd_wdata  = 32'hDEADBEEF;
        rvfi_rs1_addr  = 5'd7;
        rvfi_rs1_rdata = 32'h11223344;
        rvfi_rs2_addr  = 5'd3;
        rvfi_rs2_rdata = 32'h0;
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_n1: tx_valid=%b want 0", s_valid);
        end
        tick(1'b0, 1'b1, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_n2: valid=%b data=%h want 1/a5", s_valid, s_data);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_drain: timeout got 1 want 0");
        end
        checks++;
        if (obs_q.size() != 16) begin
            errors++;
            $display("FAIL single_len: got %0d want 16", obs_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (obs_q[i] !== gold[i] || obs_last_q[i] !== (i == 15)) begin
                    errors++;
                    $display("FAIL single_b%0d: got %h/%b want %h/%b", i, obs_q[i], obs_last_q[i], gold[i], i == 15);
                end
            end
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL single_model: diff at %0d", d);
        end
    endtask

    task automatic test_back_to_back();
        int run = 0;
        int d;
        bit ok;
        do_reset();
        set_rand();
        tick(1'b1, 1'b1, 1'b1);
        set_rand();
        tick(1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 80; n++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (s_valid) run++;
            else if (run > 0) break;
        end
        checks++;
        if (run != 32) begin
            errors++;
            $display("FAIL b2b_run: got %0d want 32", run);
        end
        drain(ok);
        checks++;
        if (obs_q.size() < 18 || obs_q[1][7:5] !== 3'd0 || obs_q[17][7:5] !== 3'd1) begin
            errors++;
            $display("FAIL b2b_seq: got %h,%h want seq 0,1", obs_q[1], obs_q[17]);
        end
        d = first_diff();
        checks++;
        if (d != -1 || !ok) begin
            errors++;
            $display("FAIL b2b_model: diff at %0d got ok=%b want -1", d, ok);
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        int d;
        bit ok;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_rand();
            tick(1'b1, 1'b0, 1'b1);
        end
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (fifo_level !== 3'd4 || drop_count !== 16'd3) begin
            errors++;
            $display("FAIL ovf_counts: level=%0d drop=%0d want 4/3", fifo_level, drop_count);
        end
        while (m_count >= DEPTH && n < 40) begin
            tick(1'b0, 1'b1, 1'b1);
            n++;
        end
        set_rand();
        tick(1'b1, 1'b1, 1'b1);
        drain(ok);
        checks++;
        if (!ok || obs_q.size() != 80) begin
            errors++;
            $display("FAIL ovf_len: got %0d want 80", obs_q.size());
        end else begin
            for (int p = 0; p < 5; p++) begin
                checks++;
                if (obs_q[p * 16 + 6][7] !== (p == 4)) begin
                    errors++;
                    $display("FAIL ovf_flag_p%0d: got %b want %b", p, obs_q[p * 16 + 6][7], p == 4);
                end
            end
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL ovf_model: diff at %0d", d);
        end
    endtask

    task automatic test_stall();
        logic [7:0] d0;
        logic       l0;
        logic       pv, pr, pl;
        logic [7:0] pd;
        int d;
        bit ok;
        do_reset();
        set_rand();
        tick(1'b1, 1'b1, 1'b1);
        repeat (6) tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        d0 = s_data;
        l0 = s_last;
        checks++;
        if (s_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_valid: got %b want 1", s_valid);
        end
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_data !== d0 || s_last !== l0) begin
            errors++;
            $display("FAIL stall_hold1: got %b/%h/%b want 1/%h/%b", s_valid, s_data, s_last, d0, l0);
        end
        tick(1'b0, 1'b1, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_data !== d0 || s_last !== l0) begin
            errors++;
            $display("FAIL stall_hold2: got %b/%h/%b want 1/%h/%b", s_valid, s_data, s_last, d0, l0);
        end
        set_rand();
        tick(1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 80; n++) begin
            pv = s_valid;
            pd = s_data;
            pl = s_last;
            pr = tx_ready;
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b1);
            if (pv && !pr) begin
                checks++;
                if (s_valid !== 1'b1 || s_data !== pd || s_last !== pl) begin
                    errors++;
                    $display("FAIL stall_rand: got %b/%h/%b want 1/%h/%b", s_valid, s_data, s_last, pd, pl);
                end
            end
        end
        drain(ok);
        d = first_diff();
        checks++;
        if (d != -1 || !ok) begin
            errors++;
            $display("FAIL stall_model: diff at %0d got ok=%b want -1", d, ok);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int d;
        bit ok;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_rand();
            tick(1'b1, 1'b0, 1'b1);
        end
        while (hs_cnt < 41 && n < 200) begin
            tick(1'b0, 1'b1, 1'b1);
            n++;
        end
        checks++;
        if (fifo_level !== 3'd2 || drop_count !== 16'd2) begin
            errors++;
            $display("FAIL rstmid_pre: level=%0d drop=%0d want 2/2", fifo_level, drop_count);
        end
        do_reset();
        checks++;
        if (tx_valid !== 1'b0 || fifo_level !== 3'd0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_post: valid=%b level=%0d drop=%0d want 0/0/0", tx_valid, fifo_level, drop_count);
        end
        set_rand();
        tick(1'b1, 1'b1, 1'b1);
        drain(ok);
        checks++;
        if (obs_q.size() != 16 || obs_q[1][7:5] !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_seq: len=%0d b1=%h want 16/seq0", obs_q.size(), obs_q[1]);
        end
        d = first_diff();
        checks++;
        if (d != -1 || !ok) begin
            errors++;
            $display("FAIL rstmid_model: diff at %0d got ok=%b want -1", d, ok);
        end
    endtask

    task automatic test_enable();
        int n = 0;
        int d;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_rand();
            tick(1'b1, 1'b1, 1'b0);
        end
        repeat (4) tick(1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_q.size() != 0 || drop_count !== 16'd0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL en_idle: bytes=%0d drop=%0d level=%0d want 0/0/0", obs_q.size(), drop_count, fifo_level);
        end
        for (int i = 0; i < 4; i++) begin
            set_rand();
            tick(1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            set_rand();
            tick(1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (fifo_level !== 3'd4 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL en_full: level=%0d drop=%0d want 4/0", fifo_level, drop_count);
        end
        while ((m_count > 0 || tx_valid) && n < 300) begin
            tick(1'b0, 1'b1, 1'b0);
            n++;
        end
        d = first_diff();
        checks++;
        if (d != -1 || obs_q.size() != 64) begin
            errors++;
            $display("FAIL en_drain: diff at %0d len=%0d want -1/64", d, obs_q.size());
        end
    endtask

    task automatic test_seq_wrap();
        int d;
        bit ok;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_rand();
            tick(1'b1, 1'b1, 1'b1);
            repeat (18) tick(1'b0, 1'b1, 1'b1);
        end
        drain(ok);
        checks++;
        if (obs_q.size() != 144 || obs_q[113][7:5] !== 3'd7 || obs_q[129][7:5] !== 3'd0) begin
            errors++;
            $display("FAIL seq_wrap: len=%0d b1_8=%h b1_9=%h want 144/seq7/seq0", obs_q.size(), obs_q[113], obs_q[129]);
        end
        d = first_diff();
        checks++;
        if (d != -1 || !ok) begin
            errors++;
            $display("FAIL seq_model: diff at %0d got ok=%b want -1", d, ok);
        end
    endtask

    task automatic test_random();
        logic       pv, pr, pl;
        logic [7:0] pd;
        int d;
        bit ok;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            pv = s_valid;
            pd = s_data;
            pl = s_last;
            pr = tx_ready;
            set_rand();
            tick(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) != 0));
            if (pv && !pr && n > 0) begin
                checks++;
                if (s_valid !== 1'b1 || s_data !== pd || s_last !== pl) begin
                    errors++;
                    $display("FAIL rand_hold: got %b/%h/%b want 1/%h/%b", s_valid, s_data, s_last, pd, pl);
                end
            end
            checks++;
            if (fifo_level !== 3'(m_count) || drop_count !== 16'(m_drop)) begin
                errors++;
                $display("FAIL rand_counts: level=%0d drop=%0d want %0d/%0d", fifo_level, drop_count, m_count, m_drop);
            end
        end
        drain(ok);
        d = first_diff();
        checks++;
        if (d != -1 || !ok) begin
            errors++;
            $display("FAIL rand_model: diff at %0d len=%0d want -1/%0d", d, obs_q.size(), exp_q.size());
        end
    endtask

    initial begin
        rst            = 1'b0;
        en             = 1'b0;
        rvfi_valid     = 1'b0;
        tx_ready       = 1'b0;
        rvfi_rd_addr   = '0;
        rvfi_rs1_addr  = '0;
        rvfi_rs2_addr  = '0;
        rvfi_rd_wdata  = '0;
        rvfi_rs1_rdata = '0;
        rvfi_rs2_rdata = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_enable();
        test_seq_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rvfi_trace_tx.md
Name: rvfi_trace_tx

Overview:
- Transmitter end of the RVFI retirement interface: captures each retired-instruction record (rd write, rs1/rs2 reads) from ibex_top's RVFI outputs.
- Buffers records in a small FIFO and serializes each one as a fixed 16-byte packet on an 8-bit valid/ready stream.
- The packet stream feeds an off-core trace sink, which consumes the same register-consistency data the formal checkers observe.
- Sits alongside ibex_top and is bound or instantiated at the core boundary.

Parameters:
- DEPTH, 4, record FIFO depth; must be a power of two and ≥2.
- SYNC_BYTE, 8'hA5, value of packet byte 0.

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-low
- en  input  1  capture enable; when low, rvfi_valid is ignored and no drop is counted
- rvfi_valid  input  1  retirement strobe
- rvfi_rd_addr  input  5  destination register
- rvfi_rd_wdata  input  32  destination write data
- rvfi_rs1_addr  input  5  source 1 register
- rvfi_rs1_rdata  input  32  source 1 read data
- rvfi_rs2_addr  input  5  source 2 register
- rvfi_rs2_rdata  input  32  source 2 read data
- tx_valid  output  1  byte valid
- tx_ready  input  1  sink ready
- tx_data  output  8  packet byte
- tx_last  output  1  high on byte 15 of a packet
- fifo_level  output  $clog2(DEPTH)+1  records currently buffered
- drop_count  output  16  records lost to FIFO full; saturates at 16'hFFFF

Behaviour:
- Reset (rst==0 at a posedge):
  - tx_valid=0, tx_data=0, tx_last=0, fifo_level=0, drop_count=0.
  - seq=0, ovf_pending=0, state=IDLE, byte_idx=0.
  - Reset mid-packet abandons the packet and flushes the FIFO.
- Capture: a record is accepted when en && rvfi_valid && (!full || pop_this_cycle).
  - Simultaneous push and pop at full is accepted.
  - An accepted record stores the 3-bit seq and the current ovf_pending; both are captured in the record.
  - seq increments (wraps 7→0); ovf_pending clears.
- Drop: en && rvfi_valid && full && !pop_this_cycle.
  - Record discarded; ovf_pending<=1; drop_count increments, saturating.
- Packet layout, in byte order:
  - b0: SYNC_BYTE
  - b1: {seq[2:0], rd_addr}
  - b2..b5: rd_wdata, little-endian
  - b6: {ovf, 2'b00, rs1_addr}
  - b7..b10: rs1_rdata, little-endian
  - b11: {3'b000, rs2_addr}
  - b12..b15: rs2_rdata, little-endian
- FSM states IDLE and SEND; byte_idx is 4 bits.
  - IDLE: tx_valid=0. Go to SEND with byte_idx=0 at the next edge when FIFO is non-empty.
  - SEND: tx_valid=1; tx_data = byte byte_idx of the FIFO head; tx_last = (byte_idx==15).
  - On tx_valid&&tx_ready with byte_idx<15: byte_idx++.
  - On tx_valid&&tx_ready with byte_idx==15: pop the head. If records remain after the pop (including a same-cycle push), stay in SEND with byte_idx=0 (back-to-back, no bubble). Otherwise go to IDLE.
- Stream rule: while tx_valid && !tx_ready, tx_data and tx_last hold stable. tx_valid never drops mid-packet.
- tx_data=0 whenever tx_valid=0.
- Latency: with the FIFO empty and in IDLE, rvfi_valid in cycle N gives b0 with tx_valid=1 in cycle N+2.
- en affects capture only; the packet in flight and buffered records always drain.
- fifo_level reflects pushes and pops registered at the edge.

Decomposition:
- Package rvfi_trace_pkg:
  - rvfi_rec_t packed struct (seq, ovf, rd/rs1/rs2 addr+data)
  - PKT_BYTES=16
  - tx_state_e {IDLE, SEND}
  - function pkt_byte(rvfi_rec_t, idx) returning 8 bits
- Sub-module rvfi_rec_fifo:
  - Parameterized DEPTH; sync FIFO of rvfi_rec_t with push/pop/full/empty/level.
  - Same-cycle push+pop at full permitted.

Test Plan:
- Single record (rd=7, wdata=32'hDEADBEEF, rs1=7/32'h11223344, rs2=3/32'h0) with tx_ready=1 → b0 in cycle N+2, then A5,07,EF,BE,AD,DE,07,44,33,22,11,03,00,00,00,00; tx_last only on the 16th byte.
- Two records on consecutive cycles, tx_ready=1 → 32 contiguous valid bytes with no bubble; b1 seq fields 0 then 1.
- DEPTH=4, tx_ready=0, 7 rvfi_valid pulses → fifo_level=4, drop_count=3. After tx_ready=1 and a further pulse, that 5th-accepted packet has b6[7]=1; the first four have b6[7]=0.
- tx_ready toggled 1,0,0,1 mid-packet → tx_data and tx_last unchanged across the stall cycles; no byte skipped or repeated.
- rst=0 asserted at byte_idx=9 with 2 records buffered → next cycle tx_valid=0, fifo_level=0, drop_count=0; the next record sent has seq=0.
- en=0 with 5 rvfi_valid pulses → no packets, drop_count=0. seq wrap: 9 accepted records → 9th packet b1[7:5]=0.
